// File: rtl/riscv_pkg.sv
// riscv_pkg: shared funct3 load/store codes and MEM-stage FSM state type
package riscv_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: selects the addressed lane of a load word and sign/zero-extends it
// Ports: word_i raw memory word, off_i byte offset, funct3_i access type, data_o formatted result
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [31:0] sh;
    always_comb begin
        sh = word_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_LB:   data_o = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   data_o = {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  data_o = {24'd0, sh[7:0]};
            F3_LHU:  data_o = {16'd0, sh[15:0]};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V MEM stage with valid/ready data port, stall control and MEM/WB register
// Inputs: EX/MEM contents (ALU_OUT_MEM address, REG_DATA2_MEM store data, FUNCT3_MEM, Mem*/RegWrite/MemtoReg, RD_MEM), dmem_ready/dmem_rdata
// Outputs: registered dmem_req/we/addr/wdata/be, combinational STALL_MEM, MEM/WB register (*_WB)
// Option: MEM_MISALIGN_TRAP_EN traps misaligned accesses (MISALIGN_WB); otherwise low address bits are cleared
module mem_access_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_OUT_MEM,
    input  logic [31:0] REG_DATA2_MEM,
    input  logic [2:0]  FUNCT3_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        RegWrite_MEM,
    input  logic        MemtoReg_MEM,
    input  logic [4:0]  RD_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        STALL_MEM,
    output logic [31:0] READ_DATA_WB,
    output logic [31:0] ALU_DATA_WB,
    output logic [4:0]  RD_WB,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        MISALIGN_WB
`endif
);
    mem_state_t state_q, state_d;
    logic [31:0] rdata_q, fmt, wdata_n;
    logic [3:0]  be_n;
    logic [2:0]  f3_q;
    logic [1:0]  off_q, off;
    logic        mis_q, mem_op, is_b, is_h, trap, idle_op;
    assign mem_op  = MemRead_MEM | MemWrite_MEM;
    assign idle_op = state_q == IDLE && mem_op;
    assign is_b    = FUNCT3_MEM[1:0] == 2'b00;
    assign is_h    = FUNCT3_MEM[1:0] == 2'b01;
    // Offset forced to the natural alignment of the access size
    assign off     = is_b ? ALU_OUT_MEM[1:0] : is_h ? {ALU_OUT_MEM[1], 1'b0} : 2'b00;
    assign be_n    = !MemWrite_MEM ? 4'b1111 : is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
    assign wdata_n = is_b ? {4{REG_DATA2_MEM[7:0]}} : is_h ? {2{REG_DATA2_MEM[15:0]}} : REG_DATA2_MEM;
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op && (is_h ? ALU_OUT_MEM[0] : !is_b && ALU_OUT_MEM[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = mem_op ? (trap ? DONE : REQ) : IDLE;
            REQ:     state_d = dmem_ready ? DONE : REQ;
            default: state_d = IDLE;
        endcase
    end
    assign STALL_MEM = idle_op || state_q == REQ;
    load_align u_align (
        .word_i  (rdata_q),
        .off_i   (off_q),
        .funct3_i(f3_q),
        .data_o  (fmt)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            rdata_q      <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            mis_q        <= 1'b0;
            READ_DATA_WB <= '0;
            ALU_DATA_WB  <= '0;
            RD_WB        <= '0;
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (idle_op) begin
                dmem_req   <= !trap;
                dmem_we    <= MemWrite_MEM;
                dmem_addr  <= {ALU_OUT_MEM[31:2], 2'b00};
                dmem_wdata <= wdata_n;
                dmem_be    <= be_n;
                off_q      <= off;
                f3_q       <= FUNCT3_MEM;
                mis_q      <= trap;
            end
            if (state_q == REQ && dmem_ready) begin
                dmem_req <= 1'b0;
                rdata_q  <= dmem_rdata;
            end
            // Stall cycles (IDLE with an op, REQ) load a bubble; only IDLE-idle and DONE retire
            ALU_DATA_WB  <= ALU_OUT_MEM;
            RD_WB        <= RD_MEM;
            RegWrite_WB  <= (state_q == IDLE && !mem_op) ? RegWrite_MEM : state_q == DONE ? RegWrite_MEM & !mis_q : 1'b0;
            MemtoReg_WB  <= (state_q == IDLE && !mem_op) || state_q == DONE ? MemtoReg_MEM : 1'b0;
            READ_DATA_WB <= (state_q == DONE && !dmem_we && !mis_q) ? fmt : '0;
        end
    end
`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) MISALIGN_WB <= 1'b0;
        else MISALIGN_WB <= state_q == DONE && mis_q;
    end
`endif
endmodule
